dmem_responder: RTL

Data-side memory responder for the pipelined RISC-V core: the slave end of the core's M-stage data port (MemWrite, ALUResult address, WriteData, byte_enable, ReadData). It decodes each access to a byte-enabled synchronous data RAM or to a small MMIO block. The MMIO block holds a 64-bit free-running machine timer with compare interrupt and a tohost halt register. Read data is registered, so it arrives in the core's W stage.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_bram.sv | 28 ++
 rtl/dmem_responder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared MMIO map, region decode type and byte-merge helper
package dmem_pkg;

    localparam logic [4:0]  OFF_MTIME_LO    = 5'h00;
    localparam logic [4:0]  OFF_MTIME_HI    = 5'h04;
    localparam logic [4:0]  OFF_MTIMECMP_LO = 5'h08;
    localparam logic [4:0]  OFF_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0]  OFF_TOHOST      = 5'h10;
    localparam logic [31:0] MMIO_SPAN       = 32'h0000_0020;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_MMIO = 2'd1,
        REG_NONE = 2'd2
    } region_e;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  be);
        return (old_v & ~lane_mask(be)) | (wdata & lane_mask(be));
    endfunction

endpackage

// File: rtl/dmem_bram.sv
// rtl/dmem_bram.sv - single-port byte-writable synchronous RAM, read-first output
module dmem_bram #(
    parameter int unsigned WORDS = 4096,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] i_addr,
    input  logic [3:0]    i_we,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [WORDS];
    logic [31:0] r_rdata;

    // Read and write share one port; the read samples the pre-write word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-port responder: RAM/MMIO decode, machine timer, tohost halt latch
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE  = 32'h1001_0000,
    parameter int unsigned DMEM_WORDS = 4096,
    parameter logic [31:0] MMIO_BASE  = 32'h2000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic [3:0]  byte_enable,
    output logic [31:0] ReadData,
    output logic        timer_irq,
    output logic        halted,
    output logic [31:0] halt_code,
    output logic        addr_err
);

    localparam int unsigned AW        = $clog2(DMEM_WORDS);
    localparam logic [31:0] DMEM_SPAN = 32'(DMEM_WORDS * 4);

    logic [31:0] w_addr;
    logic [31:0] w_ram_off;
    logic [31:0] w_mmio_off;
    logic [4:0]  w_word;
    region_e     w_region;
    logic        w_mmio_wr;
    logic [3:0]  w_ram_we;
    logic [31:0] w_ram_rdata;
    logic [31:0] w_mmio_rdata;
    logic [63:0] w_mtime_next;
    logic        w_tohost_wr;
    logic [31:0] w_tohost_next;

    region_e     r_region;
    logic [31:0] r_mmio_rdata;
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic [31:0] r_tohost;
    logic        r_halted;
    logic [31:0] r_halt_code;
    logic        r_timer_irq;
    logic        r_addr_err;

    assign w_addr     = {ALUResult[31:2], 2'b00};
    assign w_ram_off  = w_addr - DMEM_BASE;
    assign w_mmio_off = w_addr - MMIO_BASE;
    assign w_word     = w_mmio_off[4:0];

    // Unsigned offset compare covers both ends of each window at once.
    always_comb begin
        if (w_ram_off < DMEM_SPAN) begin
            w_region = REG_RAM;
        end else if (w_mmio_off < MMIO_SPAN) begin
            w_region = REG_MMIO;
        end else begin
            w_region = REG_NONE;
        end
    end

    assign w_mmio_wr = MemWrite && !rst && (w_region == REG_MMIO) && (byte_enable != 4'b0000);
    assign w_ram_we  = {4{MemWrite && !rst && (w_region == REG_RAM)}} & byte_enable;

    dmem_bram #(
        .WORDS (DMEM_WORDS),
        .AW    (AW)
    ) u_bram (
        .clk     (clk),
        .i_addr  (w_ram_off[AW+1:2]),
        .i_we    (w_ram_we),
        .i_wdata (WriteData),
        .o_rdata (w_ram_rdata)
    );

    // A write to either mtime half replaces the whole increment for that cycle.
    always_comb begin
        w_mtime_next = r_mtime + 64'd1;
        if (w_mmio_wr && (w_word == OFF_MTIME_LO)) begin
            w_mtime_next = {r_mtime[63:32], byte_merge(r_mtime[31:0], WriteData, byte_enable)};
        end else if (w_mmio_wr && (w_word == OFF_MTIME_HI)) begin
            w_mtime_next = {byte_merge(r_mtime[63:32], WriteData, byte_enable), r_mtime[31:0]};
        end
    end

    assign w_tohost_wr   = w_mmio_wr && (w_word == OFF_TOHOST);
    assign w_tohost_next = w_tohost_wr ? byte_merge(r_tohost, WriteData, byte_enable) : r_tohost;

    always_comb begin
        case (w_word)
            OFF_MTIME_LO:    w_mmio_rdata = r_mtime[31:0];
            OFF_MTIME_HI:    w_mmio_rdata = r_mtime[63:32];
            OFF_MTIMECMP_LO: w_mmio_rdata = r_mtimecmp[31:0];
            OFF_MTIMECMP_HI: w_mmio_rdata = r_mtimecmp[63:32];
            OFF_TOHOST:      w_mmio_rdata = r_tohost;
            default:         w_mmio_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_region     <= REG_NONE;
            r_mmio_rdata <= 32'h0;
            r_mtime      <= 64'h0;
            r_mtimecmp   <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_tohost     <= 32'h0;
            r_halted     <= 1'b0;
            r_halt_code  <= 32'h0;
            r_timer_irq  <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_region     <= w_region;
            r_mmio_rdata <= w_mmio_rdata;
            r_mtime      <= w_mtime_next;
            r_timer_irq  <= (r_mtime >= r_mtimecmp);
            r_addr_err   <= (w_region == REG_NONE) && (MemWrite || (ALUResult != 32'h0));
            if (w_mmio_wr && (w_word == OFF_MTIMECMP_LO)) begin
                r_mtimecmp[31:0] <= byte_merge(r_mtimecmp[31:0], WriteData, byte_enable);
            end
            if (w_mmio_wr && (w_word == OFF_MTIMECMP_HI)) begin
                r_mtimecmp[63:32] <= byte_merge(r_mtimecmp[63:32], WriteData, byte_enable);
            end
            r_tohost <= w_tohost_next;
            // First nonzero tohost value is captured once and held until reset.
            if (w_tohost_wr && !r_halted && (w_tohost_next != 32'h0)) begin
                r_halted    <= 1'b1;
                r_halt_code <= w_tohost_next;
            end
        end
    end

    always_comb begin
        case (r_region)
            REG_RAM:  ReadData = w_ram_rdata;
            REG_MMIO: ReadData = r_mmio_rdata;
            default:  ReadData = 32'h0;
        endcase
    end

    assign timer_irq = r_timer_irq;
    assign halted    = r_halted;
    assign halt_code = r_halt_code;
    assign addr_err  = r_addr_err;

endmodule
